// File: rtl/pipe_controller_if.sv
// pipe_controller_if: decode inputs, hazard flush and staged control outputs of the pipeline controller.
interface pipe_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [5:0]           opcodeD;
    logic [5:0]           functD;
    logic                 flushE;
    logic                 branchD;
    logic                 jumpD;
    logic                 illegalD;
    logic                 muldiv_stall;
    logic                 regwriteE;
    logic                 memtoregE;
    logic                 memwriteE;
    logic                 alusrcE;
    logic                 regdstE;
    logic [ALUCTRL_W-1:0] alucontrolE;
    logic                 muldivE;
    logic                 regwriteM;
    logic                 memtoregM;
    logic                 memwriteM;
    logic                 regwriteW;
    logic                 memtoregW;
    modport master (
        output opcodeD, functD, flushE,
        input  branchD, jumpD, illegalD, muldiv_stall,
        input  regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE, muldivE,
        input  regwriteM, memtoregM, memwriteM, regwriteW, memtoregW
    );
    modport slave (
        input  opcodeD, functD, flushE,
        output branchD, jumpD, illegalD, muldiv_stall,
        output regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE, muldivE,
        output regwriteM, memtoregM, memwriteM, regwriteW, memtoregW
    );
endinterface

// File: rtl/pipe_controller.sv
// pipe_controller: MIPS control decode with ID/EX, EX/MEM, MEM/WB control staging and a mul/div stall sequencer.
module pipe_controller #(
    parameter int ALUCTRL_W     = 3,
    parameter int MULDIV_EN     = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input logic        clk,
    input logic        reset,
    pipe_controller_if.slave bus
);
    localparam int CNT_W = MULDIV_CYCLES > 2 ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES > 1 ? MULDIV_CYCLES - 2 : 0);
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic                 rw;
        logic                 m2r;
        logic                 mw;
        logic                 src;
        logic                 dst;
        logic [ALUCTRL_W-1:0] alu;
        logic                 md;
    } ctrl_t;
    ctrl_t            dec_d, e_d, e_q;
    logic [2:0]       m_d, m_q;
    logic [1:0]       w_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             branch, jump, illegal, stall;
    // f = {rw, m2r, mw, src, dst}
    function automatic ctrl_t ctl(input logic [4:0] f, input logic [2:0] alu, input logic md);
        ctrl_t c;
        c = '0;
        {c.rw, c.m2r, c.mw, c.src, c.dst} = f;
        c.alu = ALUCTRL_W'(alu);
        c.md = md;
        return c;
    endfunction
    always_comb begin
        dec_d = '0;
        branch = 1'b0;
        jump = 1'b0;
        illegal = 1'b0;
        case (bus.opcodeD)
            6'b000000: case (bus.functD)
                6'h20:   dec_d = ctl(5'b10001, 3'b010, 1'b0);
                6'h22:   dec_d = ctl(5'b10001, 3'b110, 1'b0);
                6'h24:   dec_d = ctl(5'b10001, 3'b000, 1'b0);
                6'h25:   dec_d = ctl(5'b10001, 3'b001, 1'b0);
                6'h2A:   dec_d = ctl(5'b10001, 3'b111, 1'b0);
                6'h18, 6'h19, 6'h1A, 6'h1B: begin
                    dec_d = MULDIV_EN != 0 ? ctl(5'b00000, 3'b000, 1'b1) : '0;
                    illegal = MULDIV_EN == 0;
                end
                default: illegal = 1'b1;
            endcase
            6'b100011: dec_d = ctl(5'b11010, 3'b010, 1'b0);
            6'b101011: dec_d = ctl(5'b00110, 3'b010, 1'b0);
            6'b000100: begin
                dec_d = ctl(5'b00000, 3'b110, 1'b0);
                branch = 1'b1;
            end
            6'b001000: dec_d = ctl(5'b10010, 3'b010, 1'b0);
            6'b001100: dec_d = ctl(5'b10010, 3'b000, 1'b0);
            6'b001101: dec_d = ctl(5'b10010, 3'b001, 1'b0);
            6'b001010: dec_d = ctl(5'b10010, 3'b111, 1'b0);
            6'b000010: jump = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end
    // stall drops in the op's last Execute cycle so ID/EX reloads at that edge
    assign stall = (MULDIV_EN != 0) && e_q.md && (state_q == IDLE ? (MULDIV_CYCLES > 1) : (cnt_q != '0));
    assign e_d   = stall ? e_q : bus.flushE ? '0 : dec_d;
    assign m_d   = stall ? 3'b000 : {e_q.rw, e_q.m2r, e_q.mw};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= m_q[2:1];
            if (MULDIV_EN == 0) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (e_q.md && MULDIV_CYCLES > 1) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                    BUSY: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                          else state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.branchD      = branch;
    assign bus.jumpD        = jump;
    assign bus.illegalD     = illegal;
    assign bus.muldiv_stall = stall;
    assign bus.regwriteE    = e_q.rw;
    assign bus.memtoregE    = e_q.m2r;
    assign bus.memwriteE    = e_q.mw;
    assign bus.alusrcE      = e_q.src;
    assign bus.regdstE      = e_q.dst;
    assign bus.alucontrolE  = e_q.alu;
    assign bus.muldivE      = e_q.md;
    assign bus.regwriteM    = m_q[2];
    assign bus.memtoregM    = m_q[1];
    assign bus.memwriteM    = m_q[0];
    assign bus.regwriteW    = w_q[1];
    assign bus.memtoregW    = w_q[0];
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: four parameterisations driven in lockstep and compared against an occupancy-count pipeline model.
module tb_pipe_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] fn = 6'h00;
    logic       fl = 1'b0;
    always #5 clk = ~clk;

    pipe_controller_if #(.ALUCTRL_W(3)) if0 ();
    pipe_controller_if #(.ALUCTRL_W(4)) if1 ();
    pipe_controller_if #(.ALUCTRL_W(3)) if2 ();
    pipe_controller_if #(.ALUCTRL_W(3)) if3 ();
    pipe_controller #(.ALUCTRL_W(3), .MULDIV_EN(1), .MULDIV_CYCLES(4)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    pipe_controller #(.ALUCTRL_W(4), .MULDIV_EN(1), .MULDIV_CYCLES(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    pipe_controller #(.ALUCTRL_W(3), .MULDIV_EN(1), .MULDIV_CYCLES(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    pipe_controller #(.ALUCTRL_W(3), .MULDIV_EN(0), .MULDIV_CYCLES(4)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    assign if0.opcodeD = op; assign if0.functD = fn; assign if0.flushE = fl;
    assign if1.opcodeD = op; assign if1.functD = fn; assign if1.flushE = fl;
    assign if2.opcodeD = op; assign if2.functD = fn; assign if2.flushE = fl;
    assign if3.opcodeD = op; assign if3.functD = fn; assign if3.flushE = fl;

    // {branchD, jumpD, illegalD, stall, rwE, m2rE, mwE, srcE, dstE, aluE(4), mdE, rwM, m2rM, mwM, rwW, m2rW}
    logic [18:0] obs [4];
    assign obs[0] = {if0.branchD, if0.jumpD, if0.illegalD, if0.muldiv_stall, if0.regwriteE, if0.memtoregE, if0.memwriteE,
                     if0.alusrcE, if0.regdstE, 1'b0, if0.alucontrolE, if0.muldivE, if0.regwriteM, if0.memtoregM,
                     if0.memwriteM, if0.regwriteW, if0.memtoregW};
    assign obs[1] = {if1.branchD, if1.jumpD, if1.illegalD, if1.muldiv_stall, if1.regwriteE, if1.memtoregE, if1.memwriteE,
                     if1.alusrcE, if1.regdstE, if1.alucontrolE, if1.muldivE, if1.regwriteM, if1.memtoregM,
                     if1.memwriteM, if1.regwriteW, if1.memtoregW};
    assign obs[2] = {if2.branchD, if2.jumpD, if2.illegalD, if2.muldiv_stall, if2.regwriteE, if2.memtoregE, if2.memwriteE,
                     if2.alusrcE, if2.regdstE, 1'b0, if2.alucontrolE, if2.muldivE, if2.regwriteM, if2.memtoregM,
                     if2.memwriteM, if2.regwriteW, if2.memtoregW};
    assign obs[3] = {if3.branchD, if3.jumpD, if3.illegalD, if3.muldiv_stall, if3.regwriteE, if3.memtoregE, if3.memwriteE,
                     if3.alusrcE, if3.regdstE, 1'b0, if3.alucontrolE, if3.muldivE, if3.regwriteM, if3.memtoregM,
                     if3.memwriteM, if3.regwriteW, if3.memtoregW};

    typedef struct packed {
        logic       rw, m2r, mw, src, dst;
        logic [3:0] alu;
        logic       md;
    } ctl_t;
    ctl_t       me  [4];
    logic [2:0] mm  [4];
    logic [1:0] mwb [4];
    int         rem [4];
    int         mc  [4] = '{4, 2, 1, 4};
    bit         en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int         vectors = 0;
    int         miscompares = 0;
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    logic [5:0] fns [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h19, 6'h1A, 6'h1B};

    // returns {branch, jump, illegal, control word}
    function automatic logic [12:0] golden(input logic [5:0] o, input logic [5:0] f, input bit men);
        ctl_t c = '0;
        logic b = 1'b0, j = 1'b0, ill = 1'b0;
        case (o)
            6'h00: case (f)
                6'h20: c = {5'b10001, 4'd2, 1'b0};
                6'h22: c = {5'b10001, 4'd6, 1'b0};
                6'h24: c = {5'b10001, 4'd0, 1'b0};
                6'h25: c = {5'b10001, 4'd1, 1'b0};
                6'h2A: c = {5'b10001, 4'd7, 1'b0};
                6'h18, 6'h19, 6'h1A, 6'h1B: if (men) c.md = 1'b1; else ill = 1'b1;
                default: ill = 1'b1;
            endcase
            6'h23: c = {5'b11010, 4'd2, 1'b0};
            6'h2B: c = {5'b00110, 4'd2, 1'b0};
            6'h04: begin b = 1'b1; c.alu = 4'd6; end
            6'h08: c = {5'b10010, 4'd2, 1'b0};
            6'h0C: c = {5'b10010, 4'd0, 1'b0};
            6'h0D: c = {5'b10010, 4'd1, 1'b0};
            6'h0A: c = {5'b10010, 4'd7, 1'b0};
            6'h02: j = 1'b1;
            default: ill = 1'b1;
        endcase
        return {b, j, ill, c};
    endfunction

    task automatic check(input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [12:0] g;
            logic [18:0] ex;
            g  = golden(op, fn, en[k]);
            ex = {g[12:10], me[k].md && rem[k] > 1, me[k], mm[k], mwb[k]};
            vectors++;
            assert (obs[k] === ex) else begin
                miscompares++;
                $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, obs[k], ex);
            end
        end
    endtask

    // a mul/div occupies E for mc cycles; rem counts the cycles it still has there
    task automatic advance();
        for (int k = 0; k < 4; k++) begin
            logic st;
            ctl_t ne;
            logic [12:0] g;
            st     = me[k].md && rem[k] > 1;
            g      = golden(op, fn, en[k]);
            mwb[k] = mm[k][2:1];
            mm[k]  = st ? 3'b000 : {me[k].rw, me[k].m2r, me[k].mw};
            ne     = st ? me[k] : fl ? '0 : ctl_t'(g[9:0]);
            rem[k] = st ? rem[k] - 1 : ne.md ? mc[k] : 0;
            me[k]  = ne;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            me[k] = '0; mm[k] = '0; mwb[k] = '0; rem[k] = 0;
        end
    endtask

    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic fe, input string tag);
        op = o; fn = f; fl = fe;
        #1 check(tag);
        advance();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        #1 reset = 1'b0;
        #1 model_reset();
        check({tag, "_async"});
        @(posedge clk);
        #1 check({tag, "_held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic adds(input int n);
        for (int i = 0; i < n; i++) step(6'h00, 6'h20, 1'b0, "add");
    endtask

    initial begin
        model_reset();
        #1 check("reset");
        @(negedge clk);
        reset = 1'b1;
        adds(2);
        step(6'h23, 6'h00, 1'b0, "lw");
        step(6'h2B, 6'h00, 1'b0, "sw");
        step(6'h04, 6'h00, 1'b0, "beq");
        step(6'h0D, 6'h00, 1'b0, "ori");
        step(6'h02, 6'h00, 1'b0, "j");
        adds(3);
        step(6'h23, 6'h00, 1'b1, "lw_flush");
        adds(3);
        step(6'h00, 6'h18, 1'b0, "mult");
        step(6'h00, 6'h22, 1'b1, "flush_in_stall");
        step(6'h00, 6'h2A, 1'b1, "flush_in_stall");
        adds(4);
        step(6'h3F, 6'h00, 1'b0, "bad_op");
        step(6'h00, 6'h3F, 1'b0, "bad_funct");
        step(6'h00, 6'h18, 1'b0, "mult_en0");
        adds(5);
        step(6'h00, 6'h18, 1'b0, "b2b_mult");
        step(6'h00, 6'h1A, 1'b0, "b2b_div");
        step(6'h00, 6'h19, 1'b0, "b2b_multu");
        step(6'h00, 6'h1B, 1'b0, "b2b_divu");
        adds(6);
        step(6'h00, 6'h18, 1'b0, "busy_mult");
        adds(2);
        do_reset("reset_busy");
        adds(4);
        for (int i = 0; i < 500; i++) begin
            int r;
            logic [5:0] o, f;
            r = $urandom_range(0, 11);
            o = r < 10 ? ops[r] : r == 10 ? 6'h02 : 6'($urandom);
            f = $urandom_range(0, 7) == 0 ? 6'($urandom) : fns[$urandom_range(0, 8)];
            if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
            step(o, f, $urandom_range(0, 7) == 0, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
